mpi_bus_responder: RTL and testbench
====================================

Name: mpi_bus_responder

Overview:
- Synchronous slave on the 1801VM1 MPI bus (nAD, nSYNC, nDIN, nDOUT, nWTBT, nRPLY); the responding end of the bus cycles issued by cpu_emulator.
- Implements a window of 2^AW 16-bit registers at BASE_ADDR, supporting word read, word/byte write and read-modify-write (DIN then DOUT inside one nSYNC).
- Answers every cycle with a programmable nRPLY delay and lets the BK-0011M bench add memory-mapped devices beside the parallel-port register.

Parameters:
- BASE_ADDR  16'o177700  word-aligned base of the register window; low AW+1 bits ignored
- AW  2  log2 of the number of 16-bit registers (window = 2^(AW+1) bytes)
- RPLY_DLY  1  CLKp cycles from sampled strobe to nRPLY assertion; legal range 1..15

Ports:
- CLKp  input  1  bus clock; all state changes on rising edge
- nINITp  input  1  asynchronous active-low reset
- nADp  inout  16  multiplexed address/data bus, tri1; values carried as-is, no inversion; driven only during reply of a read
- nSYNCp  input  1  active-low address strobe / cycle frame
- nDINp  input  1  active-low read strobe
- nDOUTp  input  1  active-low write strobe
- nWTBTp  input  1  active-low; during data phase of a write, low = byte write
- nRPLYp  output  1  active-low reply; driven 0 when replying, else z (pulled up on bus)
- hit  output  1  high while current cycle addresses this window
- wr_pulse  output  1  one-cycle pulse when a register is written

Behaviour:
- Reset (nINITp low, async): all registers 0, state IDLE, nADp z, nRPLYp z, hit 0, wr_pulse 0, sampled-strobe flops 1.
- Inputs nSYNCp/nDINp/nDOUTp are registered once (s_sync, s_din, s_dout); edges are detected against the previous sample.
- IDLE: at edge where nSYNCp is low and s_sync was 1, latch addr = nADp; hit = (addr[15:AW+1] == BASE_ADDR[15:AW+1]). If hit -> WAIT, else -> MISS.
- MISS: no drive, no reply; -> IDLE when nSYNCp sampled high.
- WAIT: if nDINp sampled low -> RD (cnt = RPLY_DLY-1); else if nDOUTp sampled low -> WR (cnt = RPLY_DLY-1); if both low, read wins. nSYNCp high -> IDLE.
- RD: nADp = reg[addr[AW:1]] from the first edge of RD. cnt decrements each cycle; when cnt = 0, nRPLYp = 0 and -> RD_HOLD. Net latency: nRPLYp low exactly RPLY_DLY edges after the edge sampling nDINp low.
- RD_HOLD: keep data and reply; on edge sampling nDINp high, release nADp and nRPLYp the same edge -> WAIT (RMW allowed).
- WR: same count. At the reply edge, capture nADp: word write if nWTBTp high; byte write if low, with addr[0]=0 writing [7:0] from nADp[7:0] and addr[0]=1 writing [15:8] from nADp[15:8]. wr_pulse = 1 for that cycle only. -> WR_HOLD with nRPLYp = 0.
- WR_HOLD: on nDOUTp sampled high, release nRPLYp -> WAIT.
- nSYNCp sampled high in any non-IDLE state aborts: no write if the reply edge has not been reached, nADp/nRPLYp released the same edge, hit cleared -> IDLE.
- A strobe low while nSYNCp is high is ignored.
- Address wrap: only addr[AW:1] indexes the registers; bits above AW+1 participate only in the match.
- nADp is never driven in WAIT, WR, WR_HOLD, MISS or IDLE.

Test Plan:
- Reset: nINITp low mid-RD_HOLD -> nADp z, nRPLYp z immediately (async); after release, read of each of the 4 words returns 16'h0000.
- Word write/read: write 16'o123456 to 177702, read 177702 -> nADp = 16'o123456; nRPLYp low exactly RPLY_DLY=1 edge after nDINp sampled low, released on the edge nDINp sampled high.
- Byte write: word 177704 = 16'hFFFF; write to 177705 with nWTBTp low, nADp = 16'h12xx -> reg = 16'h12FF; then byte write to 177704 with 16'hxx34 -> 16'h1234.
- Miss: cycle to 177600 -> hit 0, nRPLYp never asserted, nADp never driven for 20 cycles.
- RMW with RPLY_DLY=3: in one nSYNC, read 177706 (16'h0005), then write 16'h0006 -> reply at 3 edges each phase, final read = 16'h0006, one wr_pulse.
- Abort: nSYNCp raised 1 cycle after nDOUTp low (RPLY_DLY=3) -> no wr_pulse, register unchanged, FSM in IDLE.

Source files
------------

// File: rtl/mpi_bus_responder_if.sv
// Strobe side of the 1801VM1 MPI bus as seen by a slave.
// The tri-stated nAD/nRPLY lines stay plain ports on the responder.
interface mpi_bus_responder_if;
    logic nSYNCp;
    logic nDINp;
    logic nDOUTp;
    logic nWTBTp;

    modport master (output nSYNCp, nDINp, nDOUTp, nWTBTp);
    modport slave  (input  nSYNCp, nDINp, nDOUTp, nWTBTp);
endinterface

// File: rtl/mpi_bus_responder.sv
// MPI bus slave exposing 2^AW 16-bit registers at BASE_ADDR, with word read,
// word/byte write, read-modify-write and a programmable nRPLY delay.
module mpi_bus_responder #(
    parameter logic [15:0] BASE_ADDR = 16'o177700,
    parameter int          AW        = 2,
    parameter int          RPLY_DLY  = 1
) (
    input  logic               CLKp,
    input  logic               nINITp,
    mpi_bus_responder_if.slave bus,
    inout  wire  [15:0]        nADp,
    output wire                nRPLYp,
    output logic               hit,
    output logic               wr_pulse
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MISS    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RD_HOLD = 3'd4;
    localparam logic [2:0] S_WR      = 3'd5;
    localparam logic [2:0] S_WR_HOLD = 3'd6;

    localparam int         NREG     = 1 << AW;
    localparam logic [3:0] CNT_INIT = 4'(RPLY_DLY - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW:0]   addr_q, addr_d;
    logic          hit_q, hit_d;
    logic          oe_q, oe_d;
    logic          rply_q, rply_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic          s_sync_q, s_din_q, s_dout_q;
    logic [15:0]   regs_q [NREG];
    logic [15:0]   regs_d [NREG];

    logic [AW-1:0] idx;
    logic          sync_fall, din_fall, dout_fall, match;

    assign idx       = addr_q[AW:1];
    assign sync_fall = !bus.nSYNCp && s_sync_q;
    assign din_fall  = !bus.nDINp  && s_din_q;
    assign dout_fall = !bus.nDOUTp && s_dout_q;
    assign match     = (nADp[15:AW+1] == BASE_ADDR[15:AW+1]);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        hit_d      = hit_q;
        oe_d       = oe_q;
        rply_d     = rply_q;
        wr_pulse_d = 1'b0;
        regs_d     = regs_q;

        if (state_q != S_IDLE && bus.nSYNCp) begin
            // Frame dropped: abandon the cycle before any pending write lands.
            state_d = S_IDLE;
            hit_d   = 1'b0;
            oe_d    = 1'b0;
            rply_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sync_fall) begin
                        addr_d  = nADp[AW:0];
                        hit_d   = match;
                        state_d = match ? S_WAIT : S_MISS;
                    end
                end
                S_MISS: ;
                S_WAIT: begin
                    if (din_fall) begin
                        state_d = S_RD;
                        cnt_d   = CNT_INIT;
                        oe_d    = 1'b1;
                    end else if (dout_fall) begin
                        state_d = S_WR;
                        cnt_d   = CNT_INIT;
                    end
                end
                S_RD: begin
                    if (cnt_q == 4'd0) begin
                        rply_d  = 1'b1;
                        state_d = S_RD_HOLD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_RD_HOLD: begin
                    if (bus.nDINp) begin
                        oe_d    = 1'b0;
                        rply_d  = 1'b0;
                        state_d = S_WAIT;
                    end
                end
                S_WR: begin
                    if (cnt_q == 4'd0) begin
                        if (bus.nWTBTp) begin
                            regs_d[idx] = nADp;
                        end else if (addr_q[0]) begin
                            regs_d[idx][15:8] = nADp[15:8];
                        end else begin
                            regs_d[idx][7:0] = nADp[7:0];
                        end
                        wr_pulse_d = 1'b1;
                        rply_d     = 1'b1;
                        state_d    = S_WR_HOLD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_WR_HOLD: begin
                    if (bus.nDOUTp) begin
                        rply_d  = 1'b0;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge CLKp or negedge nINITp) begin
        if (!nINITp) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            oe_q       <= 1'b0;
            rply_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            s_sync_q   <= 1'b1;
            s_din_q    <= 1'b1;
            s_dout_q   <= 1'b1;
            // NOTE: the register file is software-visible and must read 0 after init, so it is reset like any other flop.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            hit_q      <= hit_d;
            oe_q       <= oe_d;
            rply_q     <= rply_d;
            wr_pulse_q <= wr_pulse_d;
            s_sync_q   <= bus.nSYNCp;
            s_din_q    <= bus.nDINp;
            s_dout_q   <= bus.nDOUTp;
            regs_q     <= regs_d;
        end
    end

    assign nADp     = oe_q ? regs_q[idx] : 16'bz;
    assign nRPLYp   = rply_q ? 1'b0 : 1'bz;
    assign hit      = hit_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_mpi_bus_responder.sv
// Directed bench: two responders (reply delay 1 and 3) on identical strobes,
// each on its own pulled-up nAD/nRPLY lines.
module tb_mpi_bus_responder;

    logic clk    = 1'b0;
    logic n_init = 1'b0;
    always #5 clk = ~clk;

    logic        t_sync = 1'b1;
    logic        t_din  = 1'b1;
    logic        t_dout = 1'b1;
    logic        t_wtbt = 1'b1;
    logic        tb_oe  = 1'b0;
    logic [15:0] tb_dat = 16'h0000;

    mpi_bus_responder_if if1 ();
    mpi_bus_responder_if if3 ();
    assign if1.nSYNCp = t_sync;
    assign if1.nDINp  = t_din;
    assign if1.nDOUTp = t_dout;
    assign if1.nWTBTp = t_wtbt;
    assign if3.nSYNCp = t_sync;
    assign if3.nDINp  = t_din;
    assign if3.nDOUTp = t_dout;
    assign if3.nWTBTp = t_wtbt;

    tri1 [15:0] nad1, nad3;
    tri1        nrply1, nrply3;
    assign nad1 = tb_oe ? tb_dat : 16'bz;
    assign nad3 = tb_oe ? tb_dat : 16'bz;

    logic hit1, hit3, wp1, wp3;

    mpi_bus_responder #(.BASE_ADDR(16'o177700), .AW(2), .RPLY_DLY(1)) u_dut1 (
        .CLKp(clk), .nINITp(n_init), .bus(if1.slave),
        .nADp(nad1), .nRPLYp(nrply1), .hit(hit1), .wr_pulse(wp1)
    );

    mpi_bus_responder #(.BASE_ADDR(16'o177700), .AW(2), .RPLY_DLY(3)) u_dut3 (
        .CLKp(clk), .nINITp(n_init), .bus(if3.slave),
        .nADp(nad3), .nRPLYp(nrply3), .hit(hit3), .wr_pulse(wp3)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int wp_cnt1 = 0;
    int wp_cnt3 = 0;

    always @(negedge clk) begin
        if (wp1) wp_cnt1++;
        if (wp3) wp_cnt3++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_cycle(input logic [15:0] addr);
        @(negedge clk);
        tb_oe  = 1'b1;
        tb_dat = addr;
        t_sync = 1'b0;
        @(negedge clk);
        tb_oe  = 1'b0;
    endtask

    task automatic end_cycle();
        @(negedge clk);
        t_sync = 1'b1;
        @(negedge clk);
    endtask

    // Lower nDIN and wait for replies; latency counted in edges after the sampling edge.
    task automatic rd_strobe(input logic [15:0] exp, input bit chk1, input string tag);
        int l1 = -1;
        int l3 = -1;
        @(negedge clk);
        t_din = 1'b0;
        for (int i = 0; i < 20 && ((chk1 && l1 < 0) || l3 < 0); i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (chk1) check({tag, "_drive1"}, nad1, exp);
                check({tag, "_drive3"}, nad3, exp);
            end
            if (l1 < 0 && nrply1 === 1'b0) l1 = i;
            if (l3 < 0 && nrply3 === 1'b0) l3 = i;
        end
        if (chk1) begin
            check({tag, "_lat1"}, 16'(l1), 16'd1);
            check({tag, "_data1"}, nad1, exp);
        end
        check({tag, "_lat3"}, 16'(l3), 16'd3);
        check({tag, "_data3"}, nad3, exp);
    endtask

    task automatic rd_release(input bit chk1, input string tag);
        @(negedge clk);
        t_din = 1'b1;
        @(negedge clk);
        if (chk1) begin
            check({tag, "_rel_rply1"}, 16'(nrply1), 16'd1);
            check({tag, "_rel_ad1"}, nad1, 16'hFFFF);
        end
        check({tag, "_rel_rply3"}, 16'(nrply3), 16'd1);
        check({tag, "_rel_ad3"}, nad3, 16'hFFFF);
    endtask

    task automatic wr_strobe(input logic [15:0] data, input bit byte_w, input string tag);
        int l1 = -1;
        int l3 = -1;
        @(negedge clk);
        tb_oe  = 1'b1;
        tb_dat = data;
        t_wtbt = !byte_w;
        t_dout = 1'b0;
        for (int i = 0; i < 20 && (l1 < 0 || l3 < 0); i++) begin
            @(negedge clk);
            if (l1 < 0 && nrply1 === 1'b0) begin
                l1 = i;
                check({tag, "_wp1"}, 16'(wp1), 16'd1);
            end
            if (l3 < 0 && nrply3 === 1'b0) begin
                l3 = i;
                check({tag, "_wp3"}, 16'(wp3), 16'd1);
            end
        end
        check({tag, "_lat1"}, 16'(l1), 16'd1);
        check({tag, "_lat3"}, 16'(l3), 16'd3);
    endtask

    task automatic wr_release(input string tag);
        @(negedge clk);
        t_dout = 1'b1;
        tb_oe  = 1'b0;
        t_wtbt = 1'b1;
        @(negedge clk);
        check({tag, "_rel_rply1"}, 16'(nrply1), 16'd1);
        check({tag, "_rel_rply3"}, 16'(nrply3), 16'd1);
    endtask

    task automatic rd_word(input logic [15:0] addr, input logic [15:0] exp, input bit chk1, input string tag);
        start_cycle(addr);
        check({tag, "_hit3"}, 16'(hit3), 16'd1);
        rd_strobe(exp, chk1, tag);
        rd_release(chk1, tag);
        end_cycle();
    endtask

    task automatic wr_word(input logic [15:0] addr, input logic [15:0] data, input bit byte_w, input string tag);
        start_cycle(addr);
        wr_strobe(data, byte_w, tag);
        wr_release(tag);
        end_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base1;
        int base3;
        int bad;

        // Reset state
        #12;
        check("rst_ad1", nad1, 16'hFFFF);
        check("rst_rply1", 16'(nrply1), 16'd1);
        check("rst_hit1", 16'(hit1), 16'd0);
        check("rst_wp1", 16'(wp1), 16'd0);
        @(negedge clk);
        n_init = 1'b1;

        // Asynchronous reset in the middle of a read reply
        wr_word(16'o177700, 16'h1234, 1'b0, "pre_wr");
        start_cycle(16'o177700);
        rd_strobe(16'h1234, 1'b1, "pre_rd");
        #2;
        n_init = 1'b0;
        #1;
        check("arst_ad1", nad1, 16'hFFFF);
        check("arst_rply1", 16'(nrply1), 16'd1);
        check("arst_ad3", nad3, 16'hFFFF);
        check("arst_hit3", 16'(hit3), 16'd0);
        t_din  = 1'b1;
        t_sync = 1'b1;
        @(negedge clk);
        n_init = 1'b1;
        rd_word(16'o177700, 16'h0000, 1'b1, "zero0");
        rd_word(16'o177702, 16'h0000, 1'b1, "zero1");
        rd_word(16'o177704, 16'h0000, 1'b1, "zero2");
        rd_word(16'o177706, 16'h0000, 1'b1, "zero3");

        // Word write / read
        wr_word(16'o177702, 16'o123456, 1'b0, "wwr");
        rd_word(16'o177702, 16'o123456, 1'b1, "wrd");

        // Byte writes: odd address takes the high lane, even address the low lane
        wr_word(16'o177704, 16'hFFFF, 1'b0, "bfill");
        wr_word(16'o177705, 16'h12AB, 1'b1, "bhi");
        rd_word(16'o177704, 16'h12FF, 1'b1, "bhi_rd");
        wr_word(16'o177704, 16'hCD34, 1'b1, "blo");
        rd_word(16'o177704, 16'h1234, 1'b1, "blo_rd");

        // Miss: outside the window nothing answers
        start_cycle(16'o177600);
        check("miss_hit1", 16'(hit1), 16'd0);
        check("miss_hit3", 16'(hit3), 16'd0);
        @(negedge clk);
        t_din = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (nrply1 !== 1'b1 || nrply3 !== 1'b1 || nad1 !== 16'hFFFF || nad3 !== 16'hFFFF) bad++;
        end
        check("miss_quiet", 16'(bad), 16'd0);
        t_din = 1'b1;
        end_cycle();

        // Read-modify-write inside one frame
        wr_word(16'o177706, 16'h0005, 1'b0, "rmw_init");
        base1 = wp_cnt1;
        base3 = wp_cnt3;
        start_cycle(16'o177706);
        rd_strobe(16'h0005, 1'b1, "rmw_rd");
        rd_release(1'b1, "rmw_rd");
        wr_strobe(16'h0006, 1'b0, "rmw_wr");
        wr_release("rmw_wr");
        end_cycle();
        check("rmw_pulses1", 16'(wp_cnt1 - base1), 16'd1);
        check("rmw_pulses3", 16'(wp_cnt3 - base3), 16'd1);
        rd_word(16'o177706, 16'h0006, 1'b1, "rmw_final");

        // Abort: frame dropped one cycle after nDOUT, before the delay-3 reply
        base3 = wp_cnt3;
        start_cycle(16'o177706);
        @(negedge clk);
        tb_oe  = 1'b1;
        tb_dat = 16'hBEEF;
        t_dout = 1'b0;
        @(negedge clk);
        t_sync = 1'b1;
        @(negedge clk);
        t_dout = 1'b0;
        t_dout = 1'b1;
        tb_oe  = 1'b0;
        check("abort_hit3", 16'(hit3), 16'd0);
        check("abort_rply3", 16'(nrply3), 16'd1);
        repeat (4) @(negedge clk);
        check("abort_pulses3", 16'(wp_cnt3 - base3), 16'd0);
        rd_word(16'o177706, 16'h0006, 1'b0, "abort_rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
